// File: rtl/regfile_sb.sv
// MIPS integer register file: NUM_RD combinational read ports with write bypass,
// one write port, per-register pending-write scoreboard, and post-reset clear sequencer.
module regfile_sb #(
    parameter int BIT_DEPTH      = 32,
    parameter int LOG_PORT_DEPTH = 5,
    parameter int NUM_RD         = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_RD*LOG_PORT_DEPTH-1:0] addr_rd,
    output logic [NUM_RD*BIT_DEPTH-1:0]      RD,
    output logic [NUM_RD-1:0]                rd_busy,
    input  logic                             we,
    input  logic [LOG_PORT_DEPTH-1:0]        addr_wr,
    input  logic [BIT_DEPTH-1:0]             wd,
    input  logic                             iss,
    input  logic [LOG_PORT_DEPTH-1:0]        addr_iss,
    output logic                             ready
);

    localparam int DEPTH = 2 ** LOG_PORT_DEPTH;
    localparam logic [LOG_PORT_DEPTH-1:0] CNT_ONE  = LOG_PORT_DEPTH'(1);
    localparam logic [LOG_PORT_DEPTH-1:0] CNT_LAST = '1;
    localparam logic [LOG_PORT_DEPTH-1:0] ADDR_R0  = '0;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                    state, state_nxt;
    logic [LOG_PORT_DEPTH-1:0] init_cnt, init_cnt_nxt;
    logic [DEPTH-1:0]          busy, busy_nxt;
    logic [BIT_DEPTH-1:0]      reg_dat [DEPTH];
    logic                      run;
    logic                      wr_ok;

    assign run   = (state == ST_RUN);
    assign wr_ok = run && we && (addr_wr != ADDR_R0);

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        case (state)
            ST_INIT: begin
                init_cnt_nxt = init_cnt + CNT_ONE;
                if (init_cnt == CNT_LAST) state_nxt = ST_RUN;
            end
            default: ;
        endcase
    end

    // Set after clear so a same-cycle write and issue to one register leaves it pending.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) busy_nxt[addr_wr] = 1'b0;
        if (run && iss && (addr_iss != ADDR_R0)) busy_nxt[addr_iss] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            busy     <= '0;
            ready    <= 1'b0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
            busy     <= busy_nxt;
            ready    <= (state_nxt == ST_RUN);
        end
    end

    // NOTE: the array has no reset term; the INIT sequencer clears it one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) reg_dat[init_cnt] <= '0;
            else if (wr_ok)       reg_dat[addr_wr]  <= wd;
        end
    end

    always_comb begin
        RD      = '0;
        rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            logic [LOG_PORT_DEPTH-1:0] a;
            logic                      byp;
            a   = addr_rd[p*LOG_PORT_DEPTH +: LOG_PORT_DEPTH];
            byp = we && (addr_wr == a) && (a != ADDR_R0);
            if (run) begin
                if (a == ADDR_R0) RD[p*BIT_DEPTH +: BIT_DEPTH] = '0;
                else if (byp)     RD[p*BIT_DEPTH +: BIT_DEPTH] = wd;
                else              RD[p*BIT_DEPTH +: BIT_DEPTH] = reg_dat[a];
                rd_busy[p] = busy[a] & ~byp;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: init sequencing, bypass, r0 rules, scoreboard, mid-run reset.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  addr_rd;
    logic [63:0] RD;
    logic [1:0]  rd_busy;
    logic        we;
    logic [4:0]  addr_wr;
    logic [31:0] wd;
    logic        iss;
    logic [4:0]  addr_iss;
    logic        ready;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_sb #(.BIT_DEPTH(32), .LOG_PORT_DEPTH(5), .NUM_RD(2)) dut (
        .clk(clk), .rst(rst), .addr_rd(addr_rd), .RD(RD), .rd_busy(rd_busy),
        .we(we), .addr_wr(addr_wr), .wd(wd), .iss(iss), .addr_iss(addr_iss),
        .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one posedge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; addr_wr = '0; wd = '0; iss = 1'b0; addr_iss = '0; addr_rd = '0;
        step();
        rst = 1'b0;
        // T1: INIT lasts 32 cycles; writes/issues ignored; reads return 0
        we = 1'b1; addr_wr = 5'd3; wd = 32'h55; iss = 1'b1; addr_iss = 5'd3;
        addr_rd = {5'd0, 5'd3};
        #1;
        check("t1_ready_c1", ready, 0);
        check("t1_rd_init", RD, 0);
        check("t1_busy_init", rd_busy, 0);
        for (int i = 2; i <= 32; i++) begin
            step();
            check($sformatf("t1_ready_c%0d", i), ready, 0);
            check($sformatf("t1_rd_c%0d", i), RD, 0);
            check($sformatf("t1_busy_c%0d", i), rd_busy, 0);
        end
        we = 1'b0; iss = 1'b0;
        step();
        check("t1_ready_c33", ready, 1);
        check("t1_r3_zero", RD[31:0], 0);
        check("t1_r3_not_busy", rd_busy, 0);

        // T2: same-cycle bypass, then committed value
        we = 1'b1; addr_wr = 5'd5; wd = 32'hDEADBEEF; addr_rd = {5'd3, 5'd5};
        #1;
        check("t2_bypass", RD[31:0], 32'hDEADBEEF);
        check("t2_port1_r3", RD[63:32], 0);
        step();
        we = 1'b0;
        #1;
        check("t2_committed", RD[31:0], 32'hDEADBEEF);

        // T3: r0 writes dropped, r0 issues ignored
        we = 1'b1; addr_wr = 5'd0; wd = 32'hFFFFFFFF; iss = 1'b1; addr_iss = 5'd0;
        addr_rd = {5'd0, 5'd0};
        #1;
        check("t3_r0_bypass_blocked", RD, 0);
        check("t3_r0_busy_now", rd_busy, 0);
        step();
        we = 1'b0; iss = 1'b0;
        #1;
        check("t3_r0_after", RD, 0);
        check("t3_r0_busy_after", rd_busy, 0);

        // T4: issue r7, then write resolves the hazard through the bypass
        iss = 1'b1; addr_iss = 5'd7; addr_rd = {5'd5, 5'd7};
        #1;
        check("t4_busy_same_cycle", rd_busy, 2'b00);
        step();
        iss = 1'b0;
        #1;
        check("t4_busy_set", rd_busy, 2'b01);
        we = 1'b1; addr_wr = 5'd7; wd = 32'h12;
        #1;
        check("t4_busy_bypassed", rd_busy, 2'b00);
        check("t4_rd_bypass", RD[31:0], 32'h12);
        check("t4_port1_r5", RD[63:32], 32'hDEADBEEF);
        step();
        we = 1'b0;
        #1;
        check("t4_busy_cleared", rd_busy, 2'b00);
        check("t4_rd_committed", RD[31:0], 32'h12);

        // T5: same-cycle write and issue to r9: set wins, data commits
        iss = 1'b1; addr_iss = 5'd9; we = 1'b1; addr_wr = 5'd9; wd = 32'h1;
        addr_rd = {5'd7, 5'd9};
        step();
        iss = 1'b0; we = 1'b0;
        #1;
        check("t5_busy_r9", rd_busy, 2'b01);
        check("t5_rd_r9", RD[31:0], 32'h1);
        check("t5_rd_r7", RD[63:32], 32'h12);

        // T6: mid-run reset clears scoreboard and array
        we = 1'b1; addr_wr = 5'd4; wd = 32'hA5; iss = 1'b1; addr_iss = 5'd6;
        step();
        we = 1'b0; iss = 1'b0; addr_rd = {5'd6, 5'd4};
        #1;
        check("t6_r4_written", RD[31:0], 32'hA5);
        check("t6_r6_busy", rd_busy, 2'b10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("t6_ready_low", ready, 0);
        check("t6_busy_low", rd_busy, 0);
        check("t6_rd_init", RD, 0);
        for (int i = 2; i <= 32; i++) begin
            step();
            check($sformatf("t6_ready_c%0d", i), ready, 0);
        end
        step();
        check("t6_ready_high", ready, 1);
        check("t6_r4_cleared", RD[31:0], 0);
        check("t6_r6_not_busy", rd_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
